blit_fill_engine: RTL

Rectangle-fill generator for the blitter at 8 bits per pixel. It takes a destination rectangle and a colour, then emits one byte-enabled 32-bit write per cycle into the blitter write FIFO, covering the rectangle row by row. It sits directly upstream of the blitter write FIFO, drives its push port, and stalls on that FIFO's `fifo_full`. The engine handles unaligned row starts and ends, applies an arbitrary row stride, and signals completion to the blitter command sequencer.

---
 rtl/blit_fill_engine.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/blit_fill_engine.sv
// Rectangle-fill generator for the 8 bpp blitter: walks a destination rectangle row by row
// and pushes one byte-enabled 32-bit colour write per cycle into the blitter write FIFO.
module blit_fill_engine (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [25:0] dst_addr,
  input  logic [15:0] width,
  input  logic [15:0] height,
  input  logic [15:0] stride,
  input  logic [7:0]  colour,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        out_write,
  output logic [25:0] out_addr,
  output logic [31:0] out_data,
  output logic [3:0]  out_byte_enable,
  input  logic        fifo_full
);

  typedef enum logic [1:0] {IDLE, FILL, FINISH} state_t;

  state_t      state_q, state_d;
  logic [25:0] row_addr_q, row_addr_d;
  logic [25:0] cur_q, cur_d;
  logic [15:0] remain_q, remain_d;
  logic [15:0] rows_q, rows_d;
  logic [15:0] width_q, width_d;
  logic [15:0] stride_q, stride_d;
  logic [7:0]  colour_q, colour_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        wr_q, wr_d;
  logic [25:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  be_q, be_d;

  // Operands of the word being issued: the incoming command on the accept cycle,
  // otherwise the walker registers. This lets the first write leave with busy.
  logic        accept;
  logic        issue;
  logic [25:0] e_row, e_cur;
  logic [15:0] e_rem, e_rows, e_width, e_stride;
  logic [7:0]  e_colour;
  logic [1:0]  off;
  logic [2:0]  room, cnt;
  logic [3:0]  mask;
  logic [15:0] rem_after;
  logic [25:0] cur_after, next_row;

  assign accept = (state_q == IDLE) && start && !busy_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    e_row    = row_addr_q;
    e_cur    = cur_q;
    e_rem    = remain_q;
    e_rows   = rows_q;
    e_width  = width_q;
    e_stride = stride_q;
    e_colour = colour_q;
    if (accept) begin
      e_row    = dst_addr;
      e_cur    = dst_addr;
      e_rem    = width;
      e_rows   = height;
      e_width  = width;
      e_stride = stride;
      e_colour = colour;
    end

    off  = e_cur[1:0];
    room = 3'd4 - {1'b0, off};
    cnt  = (e_rem < {13'd0, room}) ? e_rem[2:0] : room;
    unique case (cnt)
      3'd1:    mask = 4'b0001;
      3'd2:    mask = 4'b0011;
      3'd3:    mask = 4'b0111;
      3'd4:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    rem_after = e_rem - {13'd0, cnt};
    cur_after = e_cur + {23'd0, cnt};
    next_row  = e_row + {10'd0, e_stride};
  end

  assign issue = !abort && !fifo_full &&
                 ((state_q == FILL) || (accept && (width != 16'd0) && (height != 16'd0)));

  always_comb begin
    state_d    = state_q;
    row_addr_d = row_addr_q;
    cur_d      = cur_q;
    remain_d   = remain_q;
    rows_d     = rows_q;
    width_d    = width_q;
    stride_d   = stride_q;
    colour_d   = colour_q;
    done_d     = 1'b0;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    be_d       = be_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          width_d    = width;
          stride_d   = stride;
          colour_d   = colour;
          row_addr_d = e_row;
          cur_d      = e_cur;
          remain_d   = e_rem;
          rows_d     = e_rows;
          state_d    = ((width == 16'd0) || (height == 16'd0)) ? FINISH : FILL;
        end
      end
      FILL: ;
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      wr_d   = 1'b1;
      addr_d = {e_cur[25:2], 2'b00};
      data_d = {4{e_colour}};
      be_d   = mask << off;
      if (rem_after == 16'd0) begin
        // Each row restarts from its own row address, so alignment is per row.
        rows_d     = e_rows - 16'd1;
        row_addr_d = next_row;
        cur_d      = next_row;
        remain_d   = e_width;
        if (e_rows == 16'd1) state_d = FINISH;
      end else begin
        cur_d    = cur_after;
        remain_d = rem_after;
      end
    end

    if (abort) begin
      state_d = IDLE;
      wr_d    = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != IDLE) || done_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      row_addr_q <= '0;
      cur_q      <= '0;
      remain_q   <= '0;
      rows_q     <= '0;
      width_q    <= '0;
      stride_q   <= '0;
      colour_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      be_q       <= '0;
    end else begin
      state_q    <= state_d;
      row_addr_q <= row_addr_d;
      cur_q      <= cur_d;
      remain_q   <= remain_d;
      rows_q     <= rows_d;
      width_q    <= width_d;
      stride_q   <= stride_d;
      colour_q   <= colour_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      be_q       <= be_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign out_write       = wr_q;
  assign out_addr        = addr_q;
  assign out_data        = data_q;
  assign out_byte_enable = be_q;

endmodule
